decoder_nbit_pipe: RTL and testbench

Registered, parametrised binary-to-one-hot decoder with a valid/ready stream interface on both sides. Each accepted code of IN_W bits yields one 2^IN_W-bit one-hot word (all zeros when the enable bit is low), one cycle later, held stable under backpressure. The block is the sequential successor to the 1-bit decoder. It sits between a selector source (e.g. a register-index or opcode field) and consumers that need a decoded, flow-controlled strobe vector, and it counts completed transfers.

---
 rtl/decoder_nbit_pipe_pkg.sv | 16 +
 rtl/decoder_nbit_pipe_if.sv | 24 ++
 rtl/decoder_nbit_pipe_skid.sv | 29 ++
 rtl/decoder_nbit_pipe.sv | 67 ++++++
 tb/tb_decoder_nbit_pipe.sv | 120 ++++++++++++
 5 files changed

// File: rtl/decoder_nbit_pipe_pkg.sv
// decoder_pkg: shared word type, limits and decode function for decoder_nbit_pipe
package decoder_pkg;
  localparam int DEC_MAX_IN_W  = 6;
  localparam int DEC_MAX_OUT_W = 1 << DEC_MAX_IN_W;
  typedef struct packed {
    logic [DEC_MAX_OUT_W-1:0] onehot;
    logic                     none;
  } dec_word_t;
  function automatic dec_word_t onehot_dec(input logic [DEC_MAX_IN_W-1:0] sel, input logic en);
    dec_word_t w;
    w.onehot      = '0;
    w.onehot[sel] = en;
    w.none        = !en;
    return w;
  endfunction
endpackage

// File: rtl/decoder_nbit_pipe_if.sv
// decoder_nbit_pipe_if: input code stream, decoded output stream and transfer count
interface decoder_nbit_pipe_if #(
  parameter int IN_W  = 3,
  parameter int CNT_W = 16
);
  localparam int OUT_W = 1 << IN_W;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sel;
  logic             in_en;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;
  logic             out_none;
  logic [CNT_W-1:0] xfer_cnt;
  modport master (
    output in_valid, in_sel, in_en, out_ready,
    input  in_ready, out_valid, out_onehot, out_none, xfer_cnt
  );
  modport slave (
    input  in_valid, in_sel, in_en, out_ready,
    output in_ready, out_valid, out_onehot, out_none, xfer_cnt
  );
endinterface

// File: rtl/decoder_nbit_pipe_skid.sv
// decoder_skid: one-entry holding register that catches a word accepted while the output stage is stalled
module decoder_skid
  import decoder_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_load,
  input  logic      i_pop,
  input  dec_word_t i_word,
  output logic      o_full,
  output dec_word_t o_word
);
  logic      r_full;
  dec_word_t r_word;
  // capture on load, release when the output stage drains into us
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_word <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_word <= i_word;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end
  assign o_full = r_full;
  assign o_word = r_word;
endmodule

// File: rtl/decoder_nbit_pipe.sv
// decoder_nbit_pipe: registered binary-to-one-hot decoder with valid/ready streams; DECODER_PIPE_SKID_EN adds a 1-entry skid buffer
module decoder_nbit_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  decoder_nbit_pipe_if.slave bus
);
  localparam int OUT_W = 1 << IN_W;
  dec_word_t        r_out;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  dec_word_t        w_dec;
  dec_word_t        w_sk_word;
  logic             w_sk_full;
  logic             w_acc;
  logic             w_xfer;
  logic             w_load;
  logic             w_unused;
  assign w_dec  = onehot_dec(DEC_MAX_IN_W'(bus.in_sel), bus.in_en);
  assign w_acc  = bus.in_valid & bus.in_ready;
  assign w_xfer = r_valid & bus.out_ready;
  assign w_load = w_acc & (!r_valid | w_xfer);
`ifdef DECODER_PIPE_SKID_EN
  decoder_skid u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_acc & r_valid & !w_xfer),
    .i_pop  (w_xfer),
    .i_word (w_dec),
    .o_full (w_sk_full),
    .o_word (w_sk_word)
  );
  assign bus.in_ready = rst_n & !w_sk_full;
`else
  assign w_sk_full    = 1'b0;
  assign w_sk_word    = '0;
  assign bus.in_ready = rst_n & (!r_valid | bus.out_ready);
`endif
  // output stage: refill from skid first so order is preserved, else from the input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
    end else if (w_xfer && w_sk_full) begin
      r_out <= w_sk_word;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_out   <= w_dec;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end
  // count completed output transfers, wrapping naturally
  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else if (w_xfer) r_cnt <= r_cnt + 1'b1;
  end
  assign w_unused       = ^r_out.onehot;
  assign bus.out_valid  = r_valid;
  assign bus.out_onehot = r_out.onehot[OUT_W-1:0];
  assign bus.out_none   = r_out.none;
  assign bus.xfer_cnt   = r_cnt;
endmodule

// File: tb/tb_decoder_nbit_pipe.sv
// tb_decoder_nbit_pipe: directed checks of decode, backpressure, streaming, counter wrap and reset
module tb_decoder_nbit_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  decoder_nbit_pipe_if #(.IN_W(3), .CNT_W(16)) b ();
  decoder_nbit_pipe_if #(.IN_W(3), .CNT_W(4))  b2 ();
  decoder_nbit_pipe #(.IN_W(3), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  decoder_nbit_pipe #(.IN_W(3), .CNT_W(4))  dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
`ifdef DECODER_PIPE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    b.in_valid = 1'b0; b.in_sel = '0; b.in_en = 1'b0; b.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_sel = '0; b2.in_en = 1'b0; b2.out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", 64'(b.in_ready), 64'd0);
    chk("rst_valid", 64'(b.out_valid), 64'd0);
    chk("rst_onehot", 64'(b.out_onehot), 64'd0);
    chk("rst_none", 64'(b.out_none), 64'd0);
    chk("rst_cnt", 64'(b.xfer_cnt), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", 64'(b.in_ready), 64'd1);
    b.in_valid = 1'b1; b.in_sel = 3'd5; b.in_en = 1'b1; b.out_ready = 1'b1;
    step();
    chk("dec5_valid", 64'(b.out_valid), 64'd1);
    chk("dec5_onehot", 64'(b.out_onehot), 64'h20);
    chk("dec5_none", 64'(b.out_none), 64'd0);
    chk("dec5_cnt", 64'(b.xfer_cnt), 64'd0);
    b.in_sel = 3'd2; b.in_en = 1'b0;
    step();
    chk("dis_onehot", 64'(b.out_onehot), 64'h00);
    chk("dis_none", 64'(b.out_none), 64'd1);
    chk("dis_cnt", 64'(b.xfer_cnt), 64'd1);
    b.in_valid = 1'b0;
    step();
    chk("dis_drain_cnt", 64'(b.xfer_cnt), 64'd2);
    chk("dis_drain_valid", 64'(b.out_valid), 64'd0);
    b.out_ready = 1'b0; b.in_valid = 1'b1; b.in_sel = 3'd3; b.in_en = 1'b1;
    step();
    chk("bp_onehot", 64'(b.out_onehot), 64'h08);
    b.in_sel = 3'd6;
    chk("bp_in_ready_1", 64'(b.in_ready), 64'(SKID));
    for (int i = 0; i < 5; i++) begin
      step();
      if (SKID) b.in_valid = 1'b0;
      chk("bp_hold_valid", 64'(b.out_valid), 64'd1);
      chk("bp_hold_onehot", 64'(b.out_onehot), 64'h08);
      chk("bp_hold_none", 64'(b.out_none), 64'd0);
      chk("bp_in_ready_full", 64'(b.in_ready), 64'd0);
    end
    chk("bp_cnt_hold", 64'(b.xfer_cnt), 64'd2);
    b.out_ready = 1'b1;
    step();
    b.in_valid = 1'b0;
    chk("bp_rel_onehot", 64'(b.out_onehot), 64'h40);
    chk("bp_rel_cnt", 64'(b.xfer_cnt), 64'd3);
    step();
    chk("bp_end_cnt", 64'(b.xfer_cnt), 64'd4);
    chk("bp_end_valid", 64'(b.out_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      b.in_valid = 1'b1; b.in_sel = 3'(i); b.in_en = 1'b1;
      step();
      chk("st_valid", 64'(b.out_valid), 64'd1);
      chk("st_onehot", 64'(b.out_onehot), 64'd1 << i);
      chk("st_cnt", 64'(b.xfer_cnt), 64'(4 + i));
    end
    b.in_valid = 1'b0;
    step();
    chk("st_end_cnt", 64'(b.xfer_cnt), 64'd12);
    chk("st_end_valid", 64'(b.out_valid), 64'd0);
    b.out_ready = 1'b0; b.in_valid = 1'b1; b.in_sel = 3'd1; b.in_en = 1'b1;
    step();
    b.in_sel = 3'd2;
    step();
    b.in_valid = 1'b0;
    chk("mr_full_valid", 64'(b.out_valid), 64'd1);
    rst_n = 1'b0; b.out_ready = 1'b1;
    chk("mr_in_ready_low", 64'(b.in_ready), 64'd0);
    step();
    chk("mr_valid", 64'(b.out_valid), 64'd0);
    chk("mr_cnt", 64'(b.xfer_cnt), 64'd0);
    chk("mr_onehot", 64'(b.out_onehot), 64'd0);
    rst_n = 1'b1;
    step();
    chk("mr_in_ready", 64'(b.in_ready), 64'd1);
    chk("mr_no_stale", 64'(b.out_valid), 64'd0);
    step();
    chk("mr_no_stale2", 64'(b.out_valid), 64'd0);
    chk("mr_cnt2", 64'(b.xfer_cnt), 64'd0);
    b2.in_valid = 1'b1; b2.in_en = 1'b1; b2.out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      b2.in_sel = 3'(i);
      step();
      if (i == 16) chk("wrap_zero", 64'(b2.xfer_cnt), 64'd0);
    end
    b2.in_valid = 1'b0;
    chk("wrap_one", 64'(b2.xfer_cnt), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
